// File: rtl/local_config_dispatcher.sv
// Local config sink: decapsulates TSMP config frames into MAC, register and mapping-table writes.
// Optional LCM_CMD_CNT_EN adds saturating ok/error command counters.
module local_config_dispatcher #(
    parameter int unsigned NUM_TBL   = 4,
    parameter int unsigned TBL_AW    = 8,
    parameter int unsigned TBL_DEPTH = 256,
    parameter int unsigned TBL_DW    = 152
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [133:0]         iv_data,
    input  logic                 i_data_wr,
    input  logic                 i_initial_finish,
    output logic                 o_lcm_inpkt_pulse,
    output logic [47:0]          ov_dmac,
    output logic [47:0]          ov_smac,
    output logic [7:0]           ov_chip_port_type,
    output logic [15:0]          ov_report_type,
    output logic [1:0]           ov_hcp_state,
    output logic [TBL_DW-1:0]    ov_tbl_wdata,
    output logic [TBL_AW-1:0]    ov_tbl_waddr,
    output logic [NUM_TBL-1:0]   ov_tbl_wr
`ifdef LCM_CMD_CNT_EN
    ,
    output logic [15:0]          ov_cmd_ok_cnt,
    output logic [15:0]          ov_cmd_err_cnt
`endif
);

    localparam int unsigned EXT_WORDS = (TBL_DW <= 96) ? 0 : (TBL_DW - 96 + 127) / 128;
    localparam int unsigned CW        = 96 + 128 * EXT_WORDS;
    localparam int unsigned IW        = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;
    localparam int unsigned CNT_W     = $clog2(EXT_WORDS + 2);

    typedef enum logic [1:0] {IDLE, CMD, EXT, DROP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     entry_q, entry_d, entry_shift;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d, tbl_idx;
    logic [TBL_AW-1:0] addr_q, addr_d;
    logic [1:0]        hcp_reg;

    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [TBL_AW-1:0] wr_addr;
    logic [TBL_DW-1:0] wr_data;
    logic              head_seen, set_port, set_hcp, set_rpt, cmd_err, cmd_ok;

    logic              is_head, is_tail, is_tbl, addr_ok, last_ext;
    logic [6:0]        tgt;
    logic [23:0]       cadr;
    logic [95:0]       pld;
    logic [3:0]        unused_bits;

    assign is_head     = (iv_data[133:132] == 2'b01);
    assign is_tail     = (iv_data[133:132] == 2'b10);
    assign tgt         = iv_data[126:120];
    assign cadr        = iv_data[119:96];
    assign pld         = iv_data[95:0];
    assign unused_bits = iv_data[131:128];
    assign is_tbl      = (tgt >= 7'd2) && (32'(tgt) < NUM_TBL + 32'd2);
    assign tbl_idx     = IW'(tgt - 7'd2);
    assign addr_ok     = 32'(cadr) < TBL_DEPTH;
    assign last_ext    = (cnt_q == CNT_W'(EXT_WORDS - 1));
    // Each ext word shifts in below the payload, so the payload ends up in the top bits.
    assign entry_shift = (entry_q << 128) | CW'(iv_data[127:0]);

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wr_en     = 1'b0;
        wr_idx    = idx_q;
        wr_addr   = addr_q;
        wr_data   = entry_q[TBL_DW-1:0];
        head_seen = 1'b0;
        set_port  = 1'b0;
        set_hcp   = 1'b0;
        set_rpt   = 1'b0;
        cmd_err   = 1'b0;
        if (i_data_wr) begin
            if (is_head) begin
                head_seen = 1'b1;
                cmd_err   = (state_q == EXT) || (state_q == DROP);
                state_d   = CMD;
            end else begin
                unique case (state_q)
                    IDLE: ;
                    CMD: begin
                        if (iv_data[127]) begin
                            if (tgt == 7'd0 && cadr == 24'd0) begin
                                set_port = 1'b1;
                            end else if (tgt == 7'd1 && cadr == 24'd0) begin
                                set_hcp = 1'b1;
                            end else if (tgt == 7'd1 && cadr == 24'd1) begin
                                set_rpt = 1'b1;
                            end else if (is_tbl && addr_ok) begin
                                if (EXT_WORDS == 0) begin
                                    wr_en   = 1'b1;
                                    wr_idx  = tbl_idx;
                                    wr_addr = TBL_AW'(cadr);
                                    wr_data = TBL_DW'(pld);
                                end else begin
                                    entry_d = CW'(pld);
                                    cnt_d   = '0;
                                    idx_d   = tbl_idx;
                                    addr_d  = TBL_AW'(cadr);
                                    state_d = EXT;
                                end
                            end else if (is_tbl) begin
                                cmd_err = 1'b1;
                                if (EXT_WORDS > 0) begin
                                    cnt_d   = '0;
                                    state_d = DROP;
                                end
                            end else begin
                                cmd_err = 1'b1;
                            end
                        end
                    end
                    EXT: begin
                        entry_d = entry_shift;
                        if (last_ext) begin
                            wr_en   = 1'b1;
                            wr_data = entry_shift[TBL_DW-1:0];
                            state_d = CMD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    DROP: begin
                        if (last_ext) state_d = CMD;
                        else          cnt_d   = cnt_q + CNT_W'(1);
                    end
                    default: state_d = IDLE;
                endcase
                // A tail ends the frame after its own word is processed; an unfinished entry is an abort.
                if (is_tail) begin
                    if (state_d == EXT || state_d == DROP) cmd_err = 1'b1;
                    state_d = IDLE;
                end
            end
        end
        cmd_ok = set_port | set_hcp | set_rpt | wr_en;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q           <= IDLE;
            entry_q           <= '0;
            cnt_q             <= '0;
            idx_q             <= '0;
            addr_q            <= '0;
            hcp_reg           <= '0;
            o_lcm_inpkt_pulse <= 1'b0;
            ov_dmac           <= '0;
            ov_smac           <= '0;
            ov_chip_port_type <= 8'hff;
            ov_report_type    <= '0;
            ov_hcp_state      <= '0;
            ov_tbl_wdata      <= '0;
            ov_tbl_waddr      <= '0;
            ov_tbl_wr         <= '0;
`ifdef LCM_CMD_CNT_EN
            ov_cmd_ok_cnt     <= '0;
            ov_cmd_err_cnt    <= '0;
`endif
        end else begin
            state_q           <= state_d;
            entry_q           <= entry_d;
            cnt_q             <= cnt_d;
            idx_q             <= idx_d;
            addr_q            <= addr_d;
            o_lcm_inpkt_pulse <= head_seen;
            if (head_seen) begin
                ov_dmac <= iv_data[127:80];
                ov_smac <= iv_data[79:32];
            end
            if (set_port) ov_chip_port_type <= pld[7:0];
            if (set_hcp)  hcp_reg           <= pld[1:0];
            if (set_rpt)  ov_report_type    <= pld[15:0];
            if (!i_initial_finish)   ov_hcp_state <= 2'b00;
            else if (hcp_reg >= 2'd2) ov_hcp_state <= hcp_reg;
            else                      ov_hcp_state <= 2'b01;
            ov_tbl_wr    <= wr_en ? (NUM_TBL'(1) << wr_idx) : '0;
            ov_tbl_waddr <= wr_en ? wr_addr : '0;
            ov_tbl_wdata <= wr_en ? wr_data : '0;
`ifdef LCM_CMD_CNT_EN
            if (cmd_ok && ov_cmd_ok_cnt != 16'hffff)   ov_cmd_ok_cnt  <= ov_cmd_ok_cnt + 16'd1;
            if (cmd_err && ov_cmd_err_cnt != 16'hffff) ov_cmd_err_cnt <= ov_cmd_err_cnt + 16'd1;
`endif
        end
    end

endmodule
